// File: rtl/bullet_lane_grid.sv
// Multi-lane bullet field with a step-rate divider.
// Player bullets climb, enemy bullets fall, and head-on pairs annihilate.
// Bullets that leave the field are reported as hits, and player hits are
// accumulated into a saturating score.
module bullet_lane_grid #(
    parameter int LANES    = 8,
    parameter int ROWS     = 32,
    parameter int TICK_DIV = 25_000_000,
    parameter int COOLDOWN = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic [LANES-1:0]      fire_p,
    input  logic [LANES-1:0]      fire_e,
    output logic [LANES*ROWS-1:0] up_grid,
    output logic [LANES*ROWS-1:0] down_grid,
    output logic                  step,
    output logic [LANES-1:0]      hit_enemy,
    output logic [LANES-1:0]      hit_player,
    output logic [LANES-1:0]      collide,
    output logic [15:0]           score
);

    localparam int CNT_W = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
    localparam int CD_W  = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

    logic [CNT_W-1:0]      cnt;
    logic                  step_edge;
    logic [LANES-1:0]      pend_p, pend_e;
    logic [LANES-1:0]      req_p, req_e;
    logic [CD_W-1:0]       cd   [LANES];
    logic [CD_W-1:0]       cd_n [LANES];
    logic [LANES*ROWS-1:0] up_n, down_n;
    logic [LANES-1:0]      hit_enemy_n, hit_player_n, collide_n;
    logic [15:0]           score_n;
    logic [16:0]           score_sum;
    logic [ROWS-1:0]       u_l, d_l, nu_l, nd_l;
    logic                  ins_p_l;

    // Step strobe: last count of the divider while running; requests arriving on this edge count.
    always_comb begin
        step_edge = enable && (cnt == CNT_W'(TICK_DIV - 1));
        req_p     = pend_p | fire_p;
        req_e     = pend_e | fire_e;
    end

    // Rate divider: free-runs while enabled, holds when frozen.
    always_ff @(posedge clk) begin
        if (!resetn)
            cnt <= '0;
        else if (enable)
            cnt <= step_edge ? '0 : cnt + CNT_W'(1);
    end

    // Sticky fire requests, consumed by the next step.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pend_p <= '0;
            pend_e <= '0;
        end else if (step_edge) begin
            pend_p <= '0;
            pend_e <= '0;
        end else begin
            pend_p <= req_p;
            pend_e <= req_e;
        end
    end

    // Next field per lane: insert, shift, then remove crossing pairs and same-cell pairs.
    always_comb begin
        up_n         = up_grid;
        down_n       = down_grid;
        hit_enemy_n  = '0;
        hit_player_n = '0;
        collide_n    = '0;
        u_l          = '0;
        d_l          = '0;
        nu_l         = '0;
        nd_l         = '0;
        ins_p_l      = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            cd_n[l] = cd[l];
            ins_p_l = req_p[l] && (cd[l] == '0);
            if (ins_p_l)
                cd_n[l] = CD_W'(COOLDOWN);
            else if (cd[l] != '0)
                cd_n[l] = cd[l] - CD_W'(1);

            u_l  = up_grid[l*ROWS +: ROWS];
            d_l  = down_grid[l*ROWS +: ROWS];
            nu_l = {u_l[ROWS-2:0], ins_p_l};
            nd_l = {req_e[l], d_l[ROWS-1:1]};
            hit_enemy_n[l]  = u_l[ROWS-1];
            hit_player_n[l] = d_l[0];

            // Bullets that swap cells this step pass through each other unless removed here.
            for (int r = 0; r < ROWS - 1; r++) begin
                if (u_l[r] && d_l[r+1]) begin
                    nu_l[r+1]    = 1'b0;
                    nd_l[r]      = 1'b0;
                    collide_n[l] = 1'b1;
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                if (nu_l[r] && nd_l[r]) begin
                    nu_l[r]      = 1'b0;
                    nd_l[r]      = 1'b0;
                    collide_n[l] = 1'b1;
                end
            end
            up_n[l*ROWS +: ROWS]   = nu_l;
            down_n[l*ROWS +: ROWS] = nd_l;
        end
    end

    // Saturating score accumulation of player hits.
    always_comb begin
        score_sum = {1'b0, score};
        for (int l = 0; l < LANES; l++)
            score_sum = score_sum + 17'(hit_enemy_n[l]);
        score_n = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

    // Field state and event pulses, updated only on step edges.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            up_grid    <= '0;
            down_grid  <= '0;
            score      <= '0;
            step       <= 1'b0;
            hit_enemy  <= '0;
            hit_player <= '0;
            collide    <= '0;
            for (int l = 0; l < LANES; l++)
                cd[l] <= '0;
        end else begin
            step       <= step_edge;
            hit_enemy  <= step_edge ? hit_enemy_n  : '0;
            hit_player <= step_edge ? hit_player_n : '0;
            collide    <= step_edge ? collide_n    : '0;
            if (step_edge) begin
                up_grid   <= up_n;
                down_grid <= down_n;
                score     <= score_n;
                for (int l = 0; l < LANES; l++)
                    cd[l] <= cd_n[l];
            end
        end
    end

endmodule

// File: tb/tb_bullet_lane_grid.sv
// Bench for bullet_lane_grid: directed scenarios plus random traffic,
// compared every cycle against a bullet-list model of the field.
module tb_bullet_lane_grid;

    localparam int LANES    = 4;
    localparam int ROWS     = 8;
    localparam int TICK_DIV = 4;
    localparam int COOLDOWN = 2;

    logic                  clk = 1'b0;
    logic                  resetn = 1'b0;
    logic                  enable = 1'b0;
    logic [LANES-1:0]      fire_p = '0;
    logic [LANES-1:0]      fire_e = '0;
    logic [LANES*ROWS-1:0] up_grid, down_grid;
    logic                  step;
    logic [LANES-1:0]      hit_enemy, hit_player, collide;
    logic [15:0]           score;

    bullet_lane_grid #(
        .LANES(LANES), .ROWS(ROWS), .TICK_DIV(TICK_DIV), .COOLDOWN(COOLDOWN)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .fire_p(fire_p), .fire_e(fire_e),
        .up_grid(up_grid), .down_grid(down_grid), .step(step),
        .hit_enemy(hit_enemy), .hit_player(hit_player),
        .collide(collide), .score(score)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model: each lane holds lists of bullet row positions.
    int             uq [LANES][$];
    int             dq [LANES][$];
    int             mcd [LANES];
    bit [LANES-1:0] mpp, mpe, mhe, mhp, mcol;
    int             mcnt, mscore;
    bit             mstep;

    task automatic model_edge();
        bit se;
        if (!resetn) begin
            for (int l = 0; l < LANES; l++) begin
                uq[l].delete();
                dq[l].delete();
                mcd[l] = 0;
            end
            mpp = '0; mpe = '0; mhe = '0; mhp = '0; mcol = '0;
            mcnt = 0; mscore = 0; mstep = 0;
            return;
        end
        se    = enable && (mcnt == TICK_DIV - 1);
        mstep = se;
        mhe = '0; mhp = '0; mcol = '0;
        if (enable) mcnt = se ? 0 : mcnt + 1;
        if (!se) begin
            mpp |= fire_p;
            mpe |= fire_e;
            return;
        end
        for (int l = 0; l < LANES; l++) begin
            int pu[$];
            int pd[$];
            bit ku[$];
            bit kd[$];
            bit ins;
            pu.delete(); pd.delete(); ku.delete(); kd.delete();
            ins = (mpp[l] | fire_p[l]) && (mcd[l] == 0);
            if (ins) mcd[l] = COOLDOWN;
            else if (mcd[l] > 0) mcd[l]--;
            // Pre-step positions; new bullets enter from just outside the field.
            for (int i = 0; i < uq[l].size(); i++)
                if (uq[l][i] == ROWS - 1) mhe[l] = 1; else pu.push_back(uq[l][i]);
            for (int i = 0; i < dq[l].size(); i++)
                if (dq[l][i] == 0) mhp[l] = 1; else pd.push_back(dq[l][i]);
            if (ins) pu.push_back(-1);
            if (mpe[l] | fire_e[l]) pd.push_back(ROWS);
            for (int i = 0; i < pu.size(); i++) ku.push_back(1);
            for (int j = 0; j < pd.size(); j++) kd.push_back(1);
            // Opposing bullets that pass each other during the move.
            for (int i = 0; i < pu.size(); i++)
                for (int j = 0; j < pd.size(); j++)
                    if (ku[i] && kd[j] && pd[j] == pu[i] + 1) begin
                        ku[i] = 0; kd[j] = 0; mcol[l] = 1;
                    end
            // Opposing bullets landing in the same cell.
            for (int i = 0; i < pu.size(); i++)
                for (int j = 0; j < pd.size(); j++)
                    if (ku[i] && kd[j] && pu[i] + 1 == pd[j] - 1) begin
                        ku[i] = 0; kd[j] = 0; mcol[l] = 1;
                    end
            uq[l].delete();
            dq[l].delete();
            for (int i = 0; i < pu.size(); i++) if (ku[i]) uq[l].push_back(pu[i] + 1);
            for (int j = 0; j < pd.size(); j++) if (kd[j]) dq[l].push_back(pd[j] - 1);
        end
        mpp = '0;
        mpe = '0;
        for (int l = 0; l < LANES; l++)
            if (mhe[l] && mscore < 65535) mscore++;
    endtask

    function automatic logic [31:0] grid_of(input bit up);
        logic [31:0] g = '0;
        for (int l = 0; l < LANES; l++) begin
            if (up) for (int i = 0; i < uq[l].size(); i++) g[l*ROWS + uq[l][i]] = 1'b1;
            else    for (int i = 0; i < dq[l].size(); i++) g[l*ROWS + dq[l][i]] = 1'b1;
        end
        return g;
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("up_grid",    up_grid,    grid_of(1));
        chk("down_grid",  down_grid,  grid_of(0));
        chk("step",       32'(step),  32'(mstep));
        chk("hit_enemy",  32'(hit_enemy),  32'(mhe));
        chk("hit_player", 32'(hit_player), 32'(mhp));
        chk("collide",    32'(collide),    32'(mcol));
        chk("score",      32'(score),      32'(mscore));
    endtask

    task automatic run_steps(input int n);
        int seen  = 0;
        int guard = 0;
        while (seen < n && guard < n * TICK_DIV + 8) begin
            cyc();
            guard++;
            if (mstep) seen++;
        end
        if (seen < n) chk("step_timeout", 32'(seen), 32'(n));
    endtask

    initial begin
        int n;
        // Reset held for three cycles.
        resetn = 1'b0;
        enable = 1'b1;
        repeat (3) cyc();
        chk("rst_up",    up_grid,   32'h0);
        chk("rst_down",  down_grid, 32'h0);
        chk("rst_score", 32'(score), 32'h0);
        chk("rst_pulse", {step, hit_enemy, hit_player, collide}, 32'h0);

        // Single shot in lane 1; first step four cycles after release.
        resetn = 1'b1;
        fire_p = 4'b0010;
        cyc();
        fire_p = '0;
        n = 1;
        while (!mstep && n < 20) begin
            cyc();
            n++;
        end
        chk("first_step", 32'(n), 32'd4);
        chk("shot_step1", up_grid, 32'h0000_0100);
        run_steps(7);
        chk("shot_row7", up_grid, 32'h0000_8000);
        run_steps(1);
        chk("shot_hit",   32'(hit_enemy), 32'b0010);
        chk("shot_clear", up_grid, 32'h0);
        chk("shot_score", 32'(score), 32'd1);

        // Crossing collision in lane 2.
        fire_p = 4'b0100;
        fire_e = 4'b0100;
        cyc();
        fire_p = '0;
        fire_e = '0;
        run_steps(4);
        chk("cross_up4",   up_grid,   32'h0008_0000);
        chk("cross_down4", down_grid, 32'h0010_0000);
        run_steps(1);
        chk("cross_col",   32'(collide), 32'b0100);
        chk("cross_empty", up_grid | down_grid, 32'h0);
        chk("cross_nohit", 32'({hit_enemy, hit_player}), 32'h0);

        // Same-cell collision in lane 3, enemy one step behind.
        fire_p = 4'b1000;
        cyc();
        fire_p = '0;
        run_steps(1);
        fire_e = 4'b1000;
        cyc();
        fire_e = '0;
        run_steps(1);
        run_steps(3);
        chk("same_col", 32'(collide), 32'b1000);

        // Enemy-only shot reaches the player.
        fire_e = 4'b1000;
        cyc();
        fire_e = '0;
        run_steps(1);
        run_steps(7);
        chk("enemy_row0", down_grid, 32'h0100_0000);
        run_steps(1);
        chk("enemy_hit", 32'(hit_player), 32'b1000);

        // Cooldown with fire held on lane 0.
        fire_p = 4'b0001;
        run_steps(10);
        fire_p = '0;
        chk("cooldown", up_grid, 32'h0000_0049);

        // Freeze with requests arriving while frozen.
        fire_p = 4'b0010;
        cyc();
        fire_p = '0;
        run_steps(2);
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            fire_p = (i == 7)  ? 4'b0100 : '0;
            fire_e = (i == 11) ? 4'b0001 : '0;
            cyc();
        end
        fire_p = '0;
        fire_e = '0;
        enable = 1'b1;
        run_steps(1);
        chk("freeze_ins_up", up_grid[2*ROWS +: ROWS], 32'h1);

        // Reset mid-flight.
        fire_p = 4'b1111;
        fire_e = 4'b1010;
        cyc();
        fire_p = '0;
        fire_e = '0;
        run_steps(2);
        resetn = 1'b0;
        cyc();
        chk("midrst_grid",  up_grid | down_grid, 32'h0);
        chk("midrst_pulse", {step, hit_enemy, hit_player, collide}, 32'h0);
        resetn = 1'b1;

        // Random traffic.
        for (int i = 0; i < 900; i++) begin
            fire_p = LANES'($urandom & $urandom);
            fire_e = LANES'($urandom & $urandom);
            enable = ($urandom % 10) != 0;
            resetn = ($urandom % 250) != 0;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
